// File: rtl/game_pkg.sv
// Shared definitions for the sprite "show" blocks: sprite geometry, transparent
// key colour and the bit layout of the movement state word.
package game_pkg;

   localparam int SPR_W = 47;
   localparam int SPR_H = 41;
   localparam int SPR_PIXELS = SPR_W * SPR_H;

   typedef logic [11:0] rgb444_t;

   localparam rgb444_t KEY_COLOR = 12'h428;

   localparam int ST_FACE = 0;
   localparam int ST_AIR  = 1;
   localparam int ST_MOVE = 2;

   // Frames per direction: stand, the walk cycle, then jump.
   function automatic int frames_per_dir(input int walk_frames);
      return walk_frames + 2;
   endfunction

endpackage

// File: rtl/blue_sprite_show_if.sv
// Pixel request/response bundle between the address logic / compositor and a
// sprite show block; walk_phase is exported for observation only.
interface blue_sprite_show_if #(
   parameter int PHASE_W = 2
);
   logic [31:0]        ipcnt;
   logic [13:0]        blue;
   logic [2:0]         blue_state;
   logic [11:0]        vga_blue;
   logic [PHASE_W-1:0] walk_phase;

   // No handshake: a new pixel address is presented every clock and its
   // colour appears exactly one clock later.
   modport master (
      output ipcnt,
      output blue,
      output blue_state,
      input  vga_blue,
      input  walk_phase
   );

   modport slave (
      input  ipcnt,
      input  blue,
      input  blue_state,
      output vga_blue,
      output walk_phase
   );
endinterface

// File: rtl/sprite_rom.sv
// Single-port synchronous-read ROM; maps onto one block RAM with registered
// output. Contents are provided by the surrounding environment.
module sprite_rom #(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter int DW        = 12,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (en) r_dout <= r_mem[addr];
  end

  assign dout = r_dout;

endmodule

// File: rtl/blue_sprite_show.sv
// Player sprite pixel source: picks an animation frame from facing / air /
// walk phase and reads that frame's pixel from the sprite ROM one clock later.
module blue_sprite_show
   import game_pkg::*;
#(
   parameter int      WALK_FRAMES = 4,
   parameter int      TICK_AT     = 6_000_000,
   parameter          INIT_FILE   = "blue.mem"
) (
   input  logic               clk,
   input  logic               rstn,
   blue_sprite_show_if.slave  bus
);

   localparam int FPD   = frames_per_dir(WALK_FRAMES);
   localparam int NFRM  = 2 * FPD;
   localparam int DEPTH = NFRM * SPR_PIXELS;
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = $clog2(NFRM);
   localparam int PW    = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;

   logic          w_tick;
   logic          w_walking;
   logic          w_oob;
   logic [FW-1:0] w_local;
   logic [FW-1:0] w_frame;
   logic [AW-1:0] w_rom_addr;
   rgb444_t       w_rom_dout;

   logic [PW-1:0] r_walk_phase;
   logic          r_key;

   assign w_tick    = (bus.ipcnt == 32'(TICK_AT));
   assign w_walking = bus.blue_state[ST_MOVE] && !bus.blue_state[ST_AIR];
   assign w_oob     = (32'(bus.blue) > 32'(SPR_PIXELS - 1));

   // Any state other than walking on the ground parks the cycle at frame 0,
   // so a tick that coincides with stopping is simply ignored.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_walk_phase <= '0;
      end else if (!w_walking) begin
         r_walk_phase <= '0;
      end else if (w_tick) begin
         if (r_walk_phase == PW'(WALK_FRAMES - 1)) r_walk_phase <= '0;
         else                                     r_walk_phase <= r_walk_phase + 1'b1;
      end
   end

   always_comb begin
      w_local = '0;
      if (bus.blue_state[ST_AIR])       w_local = FW'(FPD - 1);
      else if (bus.blue_state[ST_MOVE]) w_local = FW'(1) + FW'(r_walk_phase);
      else                              w_local = '0;
   end

   // Right-facing frames come first in the ROM image.
   assign w_frame    = (bus.blue_state[ST_FACE] ? FW'(0) : FW'(FPD)) + w_local;
   assign w_rom_addr = AW'(w_frame) * AW'(SPR_PIXELS) + AW'(bus.blue);

   sprite_rom #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .DW        (12),
      .INIT_FILE (INIT_FILE)
   ) u_rom (
      .clk  (clk),
      .en   (!w_oob),
      .addr (w_rom_addr),
      .dout (w_rom_dout)
   );

   // Tracks the ROM's one-clock latency; set during reset and for
   // out-of-range pixels so those show the transparent colour.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_key <= 1'b1;
      else       r_key <= w_oob;
   end

   assign bus.vga_blue   = r_key ? KEY_COLOR : w_rom_dout;
   assign bus.walk_phase = r_walk_phase;

endmodule

// File: tb/tb_blue_sprite_show.sv
// Directed bench for blue_sprite_show with TICK_AT=10 and a synthetic image
// where every pixel of frame f is 12'h100+f (frame 0 pixel 0 is the key colour).
module tb_blue_sprite_show;
   localparam int PIX   = 47 * 41;
   localparam int DEPTH = 12 * PIX;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   blue_sprite_show_if #(.PHASE_W(2)) bus ();

   blue_sprite_show #(
      .WALK_FRAMES (4),
      .TICK_AT     (10),
      .INIT_FILE   ("")
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_image();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 0) dut.u_rom.r_mem[i] = 12'h428;
         else        dut.u_rom.r_mem[i] = 12'h100 + 12'(i / PIX);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.ipcnt = 32'd0;
      bus.blue = 14'd123;
      bus.blue_state = 3'b110;
      step();
      step();
      checks++;
      if (bus.vga_blue !== 12'h428) begin
         failures++;
         $display("FAIL reset_color got=%h exp=%h", bus.vga_blue, 12'h428);
      end
      checks++;
      if (bus.walk_phase !== 2'd0) begin
         failures++;
         $display("FAIL reset_phase got=%0d exp=0", bus.walk_phase);
      end
      bus.blue = 14'd5;
      bus.blue_state = 3'b001;
      rstn = 1'b1;
      step();
      checks++;
      if (bus.vga_blue !== 12'h100) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", bus.vga_blue, 12'h100);
      end
   endtask

   task automatic test_facing();
      logic [2:0]  st [4];
      logic [11:0] ex [4];
      st = '{3'b000, 3'b011, 3'b111, 3'b010};
      ex = '{12'h106, 12'h105, 12'h105, 12'h10B};
      bus.blue = 14'd5;
      for (int k = 0; k < 4; k++) begin
         bus.blue_state = st[k];
         step();
         checks++;
         if (bus.vga_blue !== ex[k]) begin
            failures++;
            $display("FAIL facing state=%b got=%h exp=%h", st[k], bus.vga_blue, ex[k]);
         end
      end
   endtask

   task automatic test_walk();
      logic [11:0] ex [5];
      logic [11:0] prev;
      ex = '{12'h102, 12'h103, 12'h104, 12'h101, 12'h102};
      bus.blue = 14'd5;
      bus.blue_state = 3'b101;
      bus.ipcnt = 32'd0;
      step();
      checks++;
      if (bus.vga_blue !== 12'h101) begin
         failures++;
         $display("FAIL walk_start got=%h exp=%h", bus.vga_blue, 12'h101);
      end
      prev = 12'h101;
      for (int k = 0; k < 5; k++) begin
         bus.ipcnt = 32'd10;
         step();
         checks++;
         if (bus.vga_blue !== prev) begin
            failures++;
            $display("FAIL walk_hold%0d got=%h exp=%h", k, bus.vga_blue, prev);
         end
         bus.ipcnt = 32'd3;
         step();
         checks++;
         if (bus.vga_blue !== ex[k]) begin
            failures++;
            $display("FAIL walk_step%0d got=%h exp=%h", k, bus.vga_blue, ex[k]);
         end
         prev = ex[k];
      end
      // ipcnt parked at TICK_AT ticks on every clock
      bus.ipcnt = 32'd10;
      step();
      step();
      bus.ipcnt = 32'd0;
      checks++;
      if (bus.walk_phase !== 2'd3) begin
         failures++;
         $display("FAIL walk_held_tick got=%0d exp=3", bus.walk_phase);
      end
      step();
      checks++;
      if (bus.vga_blue !== 12'h104) begin
         failures++;
         $display("FAIL walk_held_color got=%h exp=%h", bus.vga_blue, 12'h104);
      end
   endtask

   task automatic test_stop();
      bus.blue = 14'd5;
      bus.blue_state = 3'b001;
      bus.ipcnt = 32'd0;
      step();
      bus.blue_state = 3'b101;
      bus.ipcnt = 32'd10;
      step();
      step();
      bus.ipcnt = 32'd0;
      step();
      checks++;
      if (bus.vga_blue !== 12'h103 || bus.walk_phase !== 2'd2) begin
         failures++;
         $display("FAIL stop_setup got=%h/%0d exp=103/2", bus.vga_blue, bus.walk_phase);
      end
      bus.blue_state = 3'b001;
      step();
      checks++;
      if (bus.vga_blue !== 12'h100 || bus.walk_phase !== 2'd0) begin
         failures++;
         $display("FAIL stop_stand got=%h/%0d exp=100/0", bus.vga_blue, bus.walk_phase);
      end
      bus.blue_state = 3'b101;
      step();
      checks++;
      if (bus.vga_blue !== 12'h101) begin
         failures++;
         $display("FAIL stop_resume got=%h exp=%h", bus.vga_blue, 12'h101);
      end
      bus.ipcnt = 32'd10;
      step();
      checks++;
      if (bus.walk_phase !== 2'd1) begin
         failures++;
         $display("FAIL stop_tick got=%0d exp=1", bus.walk_phase);
      end
      // tick in the same cycle as stopping: stopping wins
      bus.blue_state = 3'b001;
      step();
      bus.ipcnt = 32'd0;
      checks++;
      if (bus.walk_phase !== 2'd0 || bus.vga_blue !== 12'h100) begin
         failures++;
         $display("FAIL stop_vs_tick got=%h/%0d exp=100/0", bus.vga_blue, bus.walk_phase);
      end
   endtask

   task automatic test_range();
      logic [13:0] bv [4];
      logic [2:0]  st [4];
      logic [11:0] ex [4];
      logic [13:0] sb [5];
      logic [11:0] se [5];
      logic [11:0] prev;
      bv = '{14'd1926, 14'd1927, 14'd16383, 14'd1926};
      st = '{3'b001, 3'b001, 3'b000, 3'b000};
      ex = '{12'h100, 12'h428, 12'h428, 12'h106};
      for (int k = 0; k < 4; k++) begin
         bus.blue = bv[k];
         bus.blue_state = st[k];
         step();
         checks++;
         if (bus.vga_blue !== ex[k]) begin
            failures++;
            $display("FAIL range blue=%0d got=%h exp=%h", bv[k], bus.vga_blue, ex[k]);
         end
      end
      sb = '{14'd0, 14'd3, 14'd0, 14'd1927, 14'd7};
      se = '{12'h428, 12'h100, 12'h428, 12'h428, 12'h100};
      bus.blue_state = 3'b001;
      prev = 12'h106;
      for (int k = 0; k < 5; k++) begin
         bus.blue = sb[k];
         #3;
         checks++;
         if (bus.vga_blue !== prev) begin
            failures++;
            $display("FAIL latency_early%0d got=%h exp=%h", k, bus.vga_blue, prev);
         end
         step();
         checks++;
         if (bus.vga_blue !== se[k]) begin
            failures++;
            $display("FAIL latency_track%0d got=%h exp=%h", k, bus.vga_blue, se[k]);
         end
         prev = se[k];
      end
   endtask

   task automatic test_async_reset();
      bus.blue = 14'd5;
      bus.blue_state = 3'b101;
      bus.ipcnt = 32'd10;
      step();
      step();
      bus.ipcnt = 32'd0;
      step();
      checks++;
      if (bus.vga_blue !== 12'h103) begin
         failures++;
         $display("FAIL areset_setup got=%h exp=%h", bus.vga_blue, 12'h103);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.vga_blue !== 12'h428 || bus.walk_phase !== 2'd0) begin
         failures++;
         $display("FAIL areset_now got=%h/%0d exp=428/0", bus.vga_blue, bus.walk_phase);
      end
      step();
      rstn = 1'b1;
      checks++;
      if (bus.vga_blue !== 12'h428) begin
         failures++;
         $display("FAIL areset_hold got=%h exp=%h", bus.vga_blue, 12'h428);
      end
      step();
      checks++;
      if (bus.vga_blue !== 12'h101) begin
         failures++;
         $display("FAIL areset_release got=%h exp=%h", bus.vga_blue, 12'h101);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rstn = 1'b0;
      bus.ipcnt = 32'd0;
      bus.blue = 14'd0;
      bus.blue_state = 3'b000;
      load_image();
      test_reset();
      test_facing();
      test_walk();
      test_stop();
      test_range();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
